// File: rtl/wave_chk_pkg.sv
// Shared types for the waveform sequence checker: per-signal event record,
// checker FSM states and a parameter sanity function.
package wave_chk_pkg;

  localparam int EVT_IDXW = 8;

  typedef struct packed {
    logic                rise_seen;
    logic                fall_seen;
    logic                multi;
    logic [EVT_IDXW-1:0] rise_idx;
    logic [EVT_IDXW-1:0] fall_idx;
  } sig_evt_t;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } chk_state_e;

  // Every half-cycle index of a frame must fit in idxw bits.
  function automatic bit idx_width_ok(input int idxw, input int frame_cyc);
    return (idxw >= 2) && (idxw <= EVT_IDXW) && (frame_cyc >= 2) &&
           ((1 << idxw) >= 2 * frame_cyc);
  endfunction

endpackage

// File: rtl/edge_tracker.sv
// Records one signal's rise/fall half-cycle positions within a frame and
// flags any deviation from the expected single pulse.
module edge_tracker
  import wave_chk_pkg::*;
#(
  parameter int IDXW     = 4,
  parameter int EXP_RISE = 0,
  parameter int EXP_FALL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            clear,
  input  logic            first,
  input  logic [IDXW-1:0] base,
  input  logic            a,
  input  logic            b,
  output logic            err
);

  sig_evt_t            evt;
  sig_evt_t            nxt;
  logic                prev;
  logic                lvl;
  logic                smp;
  logic [EVT_IDXW-1:0] pos;

  // clear restarts the record while the first pair of the new frame is applied.
  always_comb begin
    nxt = clear ? '0 : evt;
    lvl = clear ? 1'b0 : prev;
    smp = 1'b0;
    pos = '0;
    for (int k = 0; k < 2; k++) begin
      smp = (k == 0) ? a : b;
      pos = EVT_IDXW'(base) + EVT_IDXW'(k);
      if (k != 0 || !first) begin
        if (!lvl && smp) begin
          if (nxt.rise_seen) nxt.multi = 1'b1;
          else begin
            nxt.rise_seen = 1'b1;
            nxt.rise_idx  = pos;
          end
        end
        if (lvl && !smp) begin
          if (nxt.fall_seen) nxt.multi = 1'b1;
          else begin
            nxt.fall_seen = 1'b1;
            nxt.fall_idx  = pos;
          end
        end
      end
      lvl = smp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt  <= '0;
      prev <= 1'b0;
    end else if (valid) begin
      evt  <= nxt;
      prev <= b;
    end
  end

  assign err = evt.multi | !evt.rise_seen | !evt.fall_seen |
               (evt.fall_idx < evt.rise_idx) |
               (evt.rise_idx != EVT_IDXW'(EXP_RISE)) |
               (evt.fall_idx != EVT_IDXW'(EXP_FALL));

endmodule

// File: rtl/wave_seq_checker.sv
// Half-cycle protocol checker for sig1..sig3: samples both clock edges,
// judges each frame against expected edge positions and keeps statistics.
module wave_seq_checker
  import wave_chk_pkg::*;
#(
  parameter int FRAME_CYC = 8,
  parameter int IDXW      = 4,
  parameter int EXP_RISE1 = 4,
  parameter int EXP_FALL1 = 11,
  parameter int EXP_RISE2 = 7,
  parameter int EXP_FALL2 = 9,
  parameter int EXP_RISE3 = 6,
  parameter int EXP_FALL3 = 9,
  parameter int CNTW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sig1,
  input  logic            sig2,
  input  logic            sig3,
  output logic            frame_done,
  output logic            frame_ok,
  output logic [2:0]      err,
  output logic [CNTW-1:0] frame_cnt,
  output logic [CNTW-1:0] err_cnt,
  output chk_state_e      fsm_state
);

  localparam logic [IDXW-1:0] LAST_CYC = IDXW'(FRAME_CYC - 1);

  if (!idx_width_ok(IDXW, FRAME_CYC)) begin : g_bad_idxw
    $error("wave_seq_checker: IDXW too small for FRAME_CYC");
  end

  logic [2:0]      sig_now;
  logic [2:0]      neg_q;
  logic [2:0]      pos_q;
  logic [2:0]      sig_err;
  chk_state_e      state;
  chk_state_e      state_nxt;
  logic [IDXW-1:0] cyc;
  logic [IDXW-1:0] cyc_nxt;
  logic [IDXW-1:0] base;
  logic            trk_valid;
  logic            trk_clear;
  logic            trk_first;

  assign sig_now   = {sig3, sig2, sig1};
  assign fsm_state = state;

  always_ff @(negedge clk) begin
    if (rst) neg_q <= '0;
    else     neg_q <= sig_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SYNC;
      cyc   <= '0;
      pos_q <= '0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc_nxt;
      pos_q <= sig_now;
    end
  end

  // REPORT also feeds the new frame's first pair, so no sample is lost.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    trk_valid = 1'b0;
    trk_clear = 1'b0;
    trk_first = 1'b0;
    case (state)
      SYNC: begin
        state_nxt = RUN;
        cyc_nxt   = '0;
      end
      RUN: begin
        trk_valid = 1'b1;
        trk_first = (cyc == '0);
        if (cyc == LAST_CYC) state_nxt = REPORT;
        else                 cyc_nxt   = cyc + IDXW'(1);
      end
      REPORT: begin
        trk_valid = 1'b1;
        trk_clear = 1'b1;
        trk_first = 1'b1;
        state_nxt = RUN;
        cyc_nxt   = IDXW'(1);
      end
      default: state_nxt = SYNC;
    endcase
  end

  assign base = trk_clear ? '0 : {cyc[IDXW-2:0], 1'b0};

  edge_tracker #(.IDXW(IDXW), .EXP_RISE(EXP_RISE1), .EXP_FALL(EXP_FALL1)) u_trk1 (
    .clk(clk), .rst(rst), .valid(trk_valid), .clear(trk_clear), .first(trk_first),
    .base(base), .a(pos_q[0]), .b(neg_q[0]), .err(sig_err[0])
  );

  edge_tracker #(.IDXW(IDXW), .EXP_RISE(EXP_RISE2), .EXP_FALL(EXP_FALL2)) u_trk2 (
    .clk(clk), .rst(rst), .valid(trk_valid), .clear(trk_clear), .first(trk_first),
    .base(base), .a(pos_q[1]), .b(neg_q[1]), .err(sig_err[1])
  );

  edge_tracker #(.IDXW(IDXW), .EXP_RISE(EXP_RISE3), .EXP_FALL(EXP_FALL3)) u_trk3 (
    .clk(clk), .rst(rst), .valid(trk_valid), .clear(trk_clear), .first(trk_first),
    .base(base), .a(pos_q[2]), .b(neg_q[2]), .err(sig_err[2])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err        <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      frame_done <= (state == REPORT);
      if (state == REPORT) begin
        err       <= sig_err;
        frame_ok  <= (sig_err == 3'b000);
        frame_cnt <= frame_cnt + CNTW'(1);
        if (sig_err != 3'b000 && err_cnt != '1) err_cnt <= err_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wave_seq_checker.sv
// Directed frames driven at half-cycle resolution into a default checker and
// a narrow-counter checker, compared every cycle against a frame-level model.
module tb_wave_seq_checker;
  import wave_chk_pkg::*;

  localparam int FRAME_CYC = 8;

  // Waveforms: bit i = signal level at half-cycle index i.
  localparam logic [15:0] W1_OK    = 16'h07F0;
  localparam logic [15:0] W2_OK    = 16'h0180;
  localparam logic [15:0] W3_OK    = 16'h01C0;
  localparam logic [15:0] W2_LATE  = 16'h0600;
  localparam logic [15:0] W3_MULTI = 16'h31C0;
  localparam logic [15:0] W1_NOFAL = 16'hFFF0;
  localparam logic [15:0] W1_GLTCH = 16'h0010;
  localparam logic [15:0] W1_HIGH0 = 16'h07FF;

  logic clk = 1'b0;
  logic rst;
  logic sig1, sig2, sig3;

  logic        done_a, ok_a, done_b, ok_b;
  logic [2:0]  err_a, err_b;
  logic [15:0] fcnt_a, ecnt_a;
  logic [1:0]  fcnt_b, ecnt_b;
  chk_state_e  st_a, st_b;

  wave_seq_checker u_dut_a (
    .clk(clk), .rst(rst), .sig1(sig1), .sig2(sig2), .sig3(sig3),
    .frame_done(done_a), .frame_ok(ok_a), .err(err_a),
    .frame_cnt(fcnt_a), .err_cnt(ecnt_a), .fsm_state(st_a)
  );

  wave_seq_checker #(.CNTW(2)) u_dut_b (
    .clk(clk), .rst(rst), .sig1(sig1), .sig2(sig2), .sig3(sig3),
    .frame_done(done_b), .frame_ok(ok_b), .err(err_b),
    .frame_cnt(fcnt_b), .err_cnt(ecnt_b), .fsm_state(st_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc   = 0;
  bit rst_p = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc   = cyc + 1;
      rst_p = rst;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [34:0] exp_q[$];   // {due cycle, expected err}
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Frame-level model: exactly one rise and one fall at the expected indices;
  // index 0 has no predecessor so it can never be a transition.
  function automatic logic sig_bad(input logic [15:0] w, input int er, input int ef);
    int nr, nf, pr, pf;
    nr = 0; nf = 0; pr = -1; pf = -1;
    for (int i = 1; i < 2 * FRAME_CYC; i++) begin
      if (w[i] && !w[i-1]) begin nr++; pr = i; end
      if (!w[i] && w[i-1]) begin nf++; pf = i; end
    end
    return !(nr == 1 && nf == 1 && pr == er && pf == ef);
  endfunction

  function automatic logic [2:0] calc_err(input logic [15:0] w1, w2, w3);
    return {sig_bad(w3, 6, 9), sig_bad(w2, 7, 9), sig_bad(w1, 4, 11)};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_frame(input logic [15:0] w1, w2, w3, input int rst_at);
    int c0;
    bit aborted;
    c0 = 0;
    aborted = 1'b0;
    for (int c = 0; c < FRAME_CYC && !aborted; c++) begin
      if (c == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        aborted = 1'b1;
      end else begin
        sig1 = w1[2*c]; sig2 = w2[2*c]; sig3 = w3[2*c];
        @(posedge clk);
        #1;
        if (c == 0) c0 = cyc;
        #1;
        sig1 = w1[2*c+1]; sig2 = w2[2*c+1]; sig3 = w3[2*c+1];
        @(negedge clk);
        #2;
      end
    end
    if (!aborted) exp_q.push_back({32'(c0 + 9), calc_err(w1, w2, w3)});
  endtask

  // ---------------- compare process ----------------
  bit         started = 1'b0;
  int         mf = 0;
  int         me = 0;
  logic [2:0] m_err = 3'b000;
  logic       m_ok = 1'b0;
  logic       exp_done;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_p) begin
        started = 1'b1;
        exp_q.delete();
        mf = 0; me = 0; m_err = 3'b000; m_ok = 1'b0;
        check("state_a_reset", 32'(st_a), 32'(SYNC));
        check("state_b_reset", 32'(st_b), 32'(SYNC));
      end
      if (started) begin
        exp_done = 1'b0;
        if (exp_q.size() > 0 && exp_q[0][34:3] == 32'(cyc)) begin
          exp_done = 1'b1;
          m_err = exp_q[0][2:0];
          m_ok  = (m_err == 3'b000);
          mf++;
          if (m_err != 3'b000) me++;
          void'(exp_q.pop_front());
        end
        check("frame_done_a", 32'(done_a), 32'(exp_done));
        check("frame_done_b", 32'(done_b), 32'(exp_done));
        check("frame_ok_a", 32'(ok_a), 32'(m_ok));
        check("frame_ok_b", 32'(ok_b), 32'(m_ok));
        check("err_a", 32'(err_a), 32'(m_err));
        check("err_b", 32'(err_b), 32'(m_err));
        check("frame_cnt_a", 32'(fcnt_a), 32'(mf % 65536));
        check("err_cnt_a", 32'(ecnt_a), 32'((me > 65535) ? 65535 : me));
        check("frame_cnt_b", 32'(fcnt_b), 32'(mf % 4));
        check("err_cnt_b", 32'(ecnt_b), 32'((me > 3) ? 3 : me));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    sig1 = 1'b0; sig2 = 1'b0; sig3 = 1'b0;

    // Hand-computed pins on the model itself.
    check("model_ideal",  32'(calc_err(W1_OK, W2_OK, W3_OK)),    32'b000);
    check("model_late2",  32'(calc_err(W1_OK, W2_LATE, W3_OK)),  32'b010);
    check("model_multi3", 32'(calc_err(W1_OK, W2_OK, W3_MULTI)), 32'b100);
    check("model_nofall", 32'(calc_err(W1_NOFAL, W2_OK, W3_OK)), 32'b001);
    check("model_glitch", 32'(calc_err(W1_GLTCH, W2_OK, W3_OK)), 32'b001);
    check("model_high0",  32'(calc_err(W1_HIGH0, W2_OK, W3_OK)), 32'b001);
    check("model_zero",   32'(calc_err('0, '0, '0)),             32'b111);

    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;

    repeat (3) drive_frame(W1_OK, W2_OK, W3_OK, -1);
    drive_frame(W1_OK, W2_OK, W3_OK, -1);
    drive_frame(W1_OK, W2_LATE, W3_OK, -1);
    drive_frame(W1_OK, W2_OK, W3_OK, -1);
    drive_frame(W1_OK, W2_OK, W3_MULTI, -1);
    drive_frame(W1_NOFAL, W2_OK, W3_OK, -1);
    drive_frame(W1_OK, W2_OK, W3_OK, 5);
    drive_frame(W1_OK, W2_OK, W3_OK, -1);
    drive_frame(W1_GLTCH, W2_OK, W3_OK, -1);
    drive_frame('0, '0, '0, -1);
    drive_frame(W1_HIGH0, W2_OK, W3_OK, -1);
    drive_frame('0, '0, '0, -1);
    sig1 = 1'b0; sig2 = 1'b0; sig3 = 1'b0;

    for (int t = 0; t < 30 && exp_q.size() > 0; t++) begin
      @(negedge clk);
      #1;
    end
    check("verdicts_drained", 32'(exp_q.size()), 32'd0);

    // Since the mid-frame reset: 5 frames, 4 failing, last verdict all-bad.
    check("final_frame_cnt_a", 32'(fcnt_a), 32'd5);
    check("final_err_cnt_a",   32'(ecnt_a), 32'd4);
    check("final_frame_cnt_b", 32'(fcnt_b), 32'd1);
    check("final_err_cnt_b",   32'(ecnt_b), 32'd3);
    check("final_err_a",       32'(err_a),  32'b111);

    #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
